// File: rtl/diag_pkg.sv
// diag_pkg: opcodes, FSM states and widths shared by the diagnostics SPI monitor.
package diag_pkg;
    localparam int CNT_W = 3;
    localparam logic [7:0] CMD_HALT   = 8'h01;
    localparam logic [7:0] CMD_RUN    = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;
    localparam logic [7:0] CMD_READ   = 8'h04;
    localparam logic [7:0] CMD_WRITE  = 8'h05;
    localparam logic [7:0] CMD_VRAM   = 8'h06;
    typedef enum logic [3:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, VRAM_DATA, STATUS, IGNORE
    } state_t;
endpackage

// File: rtl/spi_slave_byte.sv
// spi_slave_byte: mode-0 SPI slave byte engine; synchronizes the SPI pins into clk,
// shifts MSB first and strobes byte_done on the 8th rising spi_clk.
module spi_slave_byte import diag_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_in,
    input  logic              tx_load,
    input  logic [DATA_W-1:0] tx_byte,
    output logic              spi_out,
    output logic              cs_idle,
    output logic              byte_done,
    output logic [DATA_W-1:0] rx_byte
);
    logic [SYNC_STAGES-1:0] clk_q, cs_q, in_q;
    logic                   sclk_d, rise, fall;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-2:0]      rx_sh;
    logic [DATA_W-1:0]      tx_sh;

    assign cs_idle   = cs_q[SYNC_STAGES-1];
    assign rise      = clk_q[SYNC_STAGES-1] & ~sclk_d;
    assign fall      = ~clk_q[SYNC_STAGES-1] & sclk_d;
    assign byte_done = rise & (cnt == CNT_W'(DATA_W - 1)) & ~cs_idle;
    assign rx_byte   = {rx_sh, in_q[SYNC_STAGES-1]};
    assign spi_out   = tx_sh[DATA_W-1] & ~cs_idle;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            clk_q  <= '0;
            cs_q   <= '1;
            in_q   <= '0;
            sclk_d <= 1'b0;
            cnt    <= '0;
            rx_sh  <= '0;
            tx_sh  <= '0;
        end else begin
            clk_q  <= {clk_q[SYNC_STAGES-2:0], spi_clk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs};
            in_q   <= {in_q[SYNC_STAGES-2:0], spi_in};
            sclk_d <= clk_q[SYNC_STAGES-1];
            if (cs_idle) begin
                cnt   <= '0;
                tx_sh <= '0;
            end else begin
                if (rise) begin
                    cnt   <= cnt + 1'b1;
                    rx_sh <= rx_byte[DATA_W-2:0];
                end
                // The falling edge between bytes keeps the freshly loaded MSB on the line.
                if (tx_load) tx_sh <= tx_byte;
                else if (fall && cnt != '0) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
        end
endmodule

// File: rtl/diag_spi_monitor.sv
// diag_spi_monitor: SPI diagnostics slave - CPU halt/run, SRAM read/write, VRAM dump, status.
// Define DIAG_RAM_WRITE_EN to enable the SRAM write command (0x05).
module diag_spi_monitor import diag_pkg::*; #(
    parameter int ADDR_W      = 16,
    parameter int VRAM_AW     = 10,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               halt,
    input  logic               spi_cs,
    input  logic               spi_clk,
    output logic               spi_out,
    input  logic               spi_in,
    output logic [ADDR_W-1:0]  ram_address,
    input  logic [DATA_W-1:0]  ram_dataout,
    output logic [DATA_W-1:0]  ram_datain,
    output logic               ram_we,
    output logic               ram_cs,
    input  logic [3:0]         configuration,
    output logic [VRAM_AW-1:0] vram_read_address,
    input  logic [DATA_W-1:0]  vram_output,
    output logic               vram_read_clock,
    output logic               vram_read_happened
);
`ifdef DIAG_RAM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif
    state_t              state, nxt;
    logic                cs_idle, byte_done, tx_load, decode;
    logic                is_wr, fetch, cap, wstb, vpend, vfetch, vcap;
    logic [DATA_W-1:0]   rx_byte, tx_byte, wdata;

    spi_slave_byte #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_byte (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_in(spi_in),
        .tx_load(tx_load), .tx_byte(tx_byte), .spi_out(spi_out), .cs_idle(cs_idle),
        .byte_done(byte_done), .rx_byte(rx_byte)
    );

    assign decode          = byte_done && state == CMD;
    assign ram_cs          = (fetch | wstb) & halt & ~cs_idle;
    assign ram_we          = WR_EN & wstb & halt & ~cs_idle;
    assign ram_datain      = WR_EN ? wdata : '0;
    assign vram_read_clock = vfetch;
    // Every completed byte reloads the shifter; read data overwrites it once fetched.
    assign tx_load = byte_done | cap | vcap;
    assign tx_byte = cap ? (halt ? ram_dataout : '0) :
                     vcap ? vram_output :
                     (decode && rx_byte == CMD_STATUS) ? {{(DATA_W-5){1'b0}}, halt, configuration} : '0;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        if (cs_idle) nxt = IDLE;
        else if (state == IDLE) nxt = CMD;
        else if (byte_done)
            case (state)
                CMD:     nxt = rx_byte == CMD_STATUS ? STATUS :
                               (rx_byte == CMD_READ || (WR_EN && rx_byte == CMD_WRITE)) ? ADDR_HI :
                               rx_byte == CMD_VRAM ? VRAM_DATA : IGNORE;
                ADDR_HI: nxt = ADDR_LO;
                ADDR_LO: nxt = is_wr ? WR_DATA : RD_DATA;
                STATUS:  nxt = IGNORE;
                default: nxt = state;
            endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            halt               <= 1'b0;
            ram_address        <= '0;
            vram_read_address  <= '0;
            vram_read_happened <= 1'b0;
            wdata              <= '0;
            {is_wr, fetch, cap, wstb, vpend, vfetch, vcap} <= '0;
        end else begin
            fetch  <= 1'b0;
            wstb   <= 1'b0;
            vpend  <= 1'b0;
            cap    <= fetch & ~cs_idle;
            vfetch <= vpend & ~cs_idle;
            vcap   <= vfetch & ~cs_idle;
            if (wstb) ram_address <= ram_address + 1'b1;
            if (cs_idle) vram_read_happened <= 1'b0;
            else if (byte_done)
                case (state)
                    CMD: begin
                        is_wr <= rx_byte == CMD_WRITE;
                        if (rx_byte == CMD_HALT) halt <= 1'b1;
                        if (rx_byte == CMD_RUN) halt <= 1'b0;
                        if (rx_byte == CMD_VRAM) begin
                            vram_read_happened <= 1'b1;
                            vram_read_address  <= '0;
                            vpend              <= 1'b1;
                        end
                    end
                    ADDR_HI: ram_address <= {ram_address[ADDR_W-DATA_W-1:0], rx_byte};
                    ADDR_LO: begin
                        ram_address <= {ram_address[ADDR_W-DATA_W-1:0], rx_byte};
                        fetch       <= ~is_wr;
                    end
                    RD_DATA: begin
                        ram_address <= ram_address + 1'b1;
                        fetch       <= 1'b1;
                    end
                    WR_DATA: begin
                        wdata <= rx_byte;
                        wstb  <= 1'b1;
                    end
                    VRAM_DATA: begin
                        vram_read_address <= vram_read_address + 1'b1;
                        vpend             <= 1'b1;
                    end
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_diag_spi_monitor.sv
// tb_diag_spi_monitor: directed SPI transactions against SRAM/VRAM models with
// hand-computed expected bytes and pulse counts.
module tb_diag_spi_monitor;
    logic        clk = 0, reset = 0, spi_cs = 1, spi_clk = 0, spi_in = 0;
    logic        halt, spi_out, ram_we, ram_cs, vram_read_clock, vram_read_happened;
    logic [15:0] ram_address;
    logic [7:0]  ram_dataout = 0, ram_datain, vram_output = 0;
    logic [3:0]  configuration = 4'hA;
    logic [9:0]  vram_read_address;
    logic [7:0]  mem [0:65535];
    logic [7:0]  vmem [0:1023];
    int errors = 0, checks = 0;
    int cs_pulses = 0, we_pulses = 0, cs_run = 0, we_run = 0, max_run = 0;

    diag_spi_monitor dut (
        .clk(clk), .reset(reset), .halt(halt), .spi_cs(spi_cs), .spi_clk(spi_clk),
        .spi_out(spi_out), .spi_in(spi_in), .ram_address(ram_address),
        .ram_dataout(ram_dataout), .ram_datain(ram_datain), .ram_we(ram_we),
        .ram_cs(ram_cs), .configuration(configuration),
        .vram_read_address(vram_read_address), .vram_output(vram_output),
        .vram_read_clock(vram_read_clock), .vram_read_happened(vram_read_happened)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_cs) begin
            if (ram_we) mem[ram_address] <= ram_datain;
            else ram_dataout <= mem[ram_address];
        end

    always @(posedge vram_read_clock) vram_output <= vmem[vram_read_address];

    always @(negedge clk) begin
        if (ram_cs && cs_run == 0) cs_pulses = cs_pulses + 1;
        if (ram_we && we_run == 0) we_pulses = we_pulses + 1;
        cs_run = ram_cs ? cs_run + 1 : 0;
        we_run = ram_we ? we_run + 1 : 0;
        if (cs_run > max_run) max_run = cs_run;
        if (we_run > max_run) max_run = we_run;
    end

    task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
        for (int i = 7; i >= 0; i--) begin
            spi_in = mosi[i];
            #40;
            miso[i] = spi_out;
            spi_clk = 1;
            #40;
            spi_clk = 0;
        end
    endtask

    task automatic cs_begin();
        cs_pulses = 0; we_pulses = 0; max_run = 0;
        spi_cs = 0;
        #40;
    endtask

    task automatic cs_end();
        #40;
        spi_cs = 1;
        #80;
    endtask

    task automatic send1(input logic [7:0] op);
        logic [7:0] r;
        cs_begin(); xfer(op, r); cs_end();
    endtask

    task automatic test_reset();
        #32;
        checks++; if (halt !== 0) begin errors++; $display("FAIL reset_halt got %h want 0", halt); end
        checks++; if (spi_out !== 0) begin errors++; $display("FAIL reset_miso got %h want 0", spi_out); end
        checks++; if ({ram_cs, ram_we, vram_read_clock, vram_read_happened} !== 4'b0)
            begin errors++; $display("FAIL reset_strobes got %b want 0000", {ram_cs, ram_we, vram_read_clock, vram_read_happened}); end
        checks++; if (ram_address !== 16'h0 || vram_read_address !== 10'h0)
            begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", ram_address, vram_read_address); end
        reset = 1;
        #40;
    endtask

    task automatic test_halt_run();
        send1(8'h01);
        checks++; if (halt !== 1) begin errors++; $display("FAIL halt_cmd got %h want 1", halt); end
        checks++; if (cs_pulses !== 0) begin errors++; $display("FAIL halt_no_cs got %0d want 0", cs_pulses); end
        send1(8'h02);
        checks++; if (halt !== 0) begin errors++; $display("FAIL run_cmd got %h want 0", halt); end
        checks++; if (cs_pulses !== 0) begin errors++; $display("FAIL run_no_cs got %0d want 0", cs_pulses); end
    endtask

    task automatic test_status();
        logic [7:0] r0, r1;
        send1(8'h01);
        cs_begin(); xfer(8'h03, r0); xfer(8'h00, r1); cs_end();
        checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL status_cmd_miso got %h want 00", r0); end
        checks++; if (r1 !== 8'h1A) begin errors++; $display("FAIL status_byte got %h want 1a", r1); end
    endtask

    task automatic test_read_wrap();
        logic [7:0] r, d0, d1, d2;
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
        cs_begin(); xfer(8'h04, r); xfer(8'hFF, r); xfer(8'hFE, r);
        xfer(8'h00, d0); xfer(8'h00, d1); xfer(8'h00, d2); cs_end();
        checks++; if ({d0, d1, d2} !== 24'h112233) begin errors++; $display("FAIL read_wrap got %h want 112233", {d0, d1, d2}); end
        checks++; if (cs_pulses !== 4) begin errors++; $display("FAIL read_cs_pulses got %0d want 4", cs_pulses); end
        checks++; if (max_run !== 1) begin errors++; $display("FAIL read_cs_width got %0d want 1", max_run); end
        checks++; if (ram_address !== 16'h0001) begin errors++; $display("FAIL read_addr_hold got %h want 0001", ram_address); end
    endtask

    task automatic test_write();
        logic [7:0] r, d0, d1;
        mem[16'h1234] = 8'h77; mem[16'h1235] = 8'h88;
        cs_begin(); xfer(8'h05, r); xfer(8'h12, r); xfer(8'h34, r);
        xfer(8'hAB, d0); xfer(8'hCD, d1); cs_end();
`ifdef DIAG_RAM_WRITE_EN
        checks++; if (we_pulses !== 2 || cs_pulses !== 2) begin errors++; $display("FAIL write_pulses got we=%0d cs=%0d want 2/2", we_pulses, cs_pulses); end
        checks++; if (max_run !== 1) begin errors++; $display("FAIL write_width got %0d want 1", max_run); end
        checks++; if ({mem[16'h1234], mem[16'h1235]} !== 16'hABCD) begin errors++; $display("FAIL write_mem got %h want abcd", {mem[16'h1234], mem[16'h1235]}); end
`else
        checks++; if (we_pulses !== 0 || cs_pulses !== 0) begin errors++; $display("FAIL write_disabled got we=%0d cs=%0d want 0/0", we_pulses, cs_pulses); end
        checks++; if ({d0, d1} !== 16'h0000) begin errors++; $display("FAIL write_ignored_miso got %h want 0000", {d0, d1}); end
`endif
        cs_begin(); xfer(8'h04, r); xfer(8'h12, r); xfer(8'h34, r);
        xfer(8'h00, d0); xfer(8'h00, d1); cs_end();
`ifdef DIAG_RAM_WRITE_EN
        checks++; if ({d0, d1} !== 16'hABCD) begin errors++; $display("FAIL write_readback got %h want abcd", {d0, d1}); end
`else
        checks++; if ({d0, d1} !== 16'h7788) begin errors++; $display("FAIL write_readback got %h want 7788", {d0, d1}); end
`endif
    endtask

    task automatic test_abort();
        logic [7:0] r, d;
        cs_begin(); xfer(8'h04, r); xfer(8'h12, r); cs_end();
        checks++; if (cs_pulses !== 0) begin errors++; $display("FAIL abort_no_cs got %0d want 0", cs_pulses); end
        checks++; if (halt !== 1) begin errors++; $display("FAIL abort_halt_kept got %h want 1", halt); end
        cs_begin(); xfer(8'h03, r); xfer(8'h00, d); cs_end();
        checks++; if (d !== 8'h1A) begin errors++; $display("FAIL abort_then_status got %h want 1a", d); end
        send1(8'h02);
        cs_begin(); xfer(8'h04, r); xfer(8'h00, r); xfer(8'h00, r); xfer(8'h00, d); cs_end();
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL run_read_data got %h want 00", d); end
        checks++; if (cs_pulses !== 0) begin errors++; $display("FAIL run_read_cs got %0d want 0", cs_pulses); end
        cs_begin(); xfer(8'h7E, r); xfer(8'h00, d); cs_end();
        checks++; if ({r, d} !== 16'h0000 || halt !== 0) begin errors++; $display("FAIL unknown_op got %h halt=%h want 0000 halt=0", {r, d}, halt); end
    endtask

    task automatic test_vram();
        logic [7:0] r, b0, b1, b1023, b1024;
        logic vrh_ok;
        vmem[0] = 8'h5A; vmem[1] = 8'h3C; vmem[1023] = 8'hC3;
        vrh_ok = 1;
        cs_begin(); xfer(8'h06, r);
        for (int i = 0; i < 1025; i++) begin
            xfer(8'h00, r);
            if (!vram_read_happened) vrh_ok = 0;
            if (i == 0) b0 = r;
            if (i == 1) b1 = r;
            if (i == 1023) b1023 = r;
            if (i == 1024) b1024 = r;
        end
        checks++; if (vrh_ok !== 1) begin errors++; $display("FAIL vram_happened_high got %b want 1", vrh_ok); end
        cs_end();
        checks++; if ({b0, b1} !== 16'h5A3C) begin errors++; $display("FAIL vram_first got %h want 5a3c", {b0, b1}); end
        checks++; if ({b1023, b1024} !== 16'hC35A) begin errors++; $display("FAIL vram_wrap got %h want c35a", {b1023, b1024}); end
        checks++; if (vram_read_happened !== 0) begin errors++; $display("FAIL vram_happened_low got %h want 0", vram_read_happened); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) vmem[i] = 8'h00;
        #2;
        test_reset();
        test_halt_run();
        test_status();
        test_read_wrap();
        test_write();
        test_abort();
        test_vram();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
